spsram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the single-port SRAM (`spsram`). Two independent requesters issue read or write transactions over a valid/ready handshake. The block grants at most one transaction per cycle and drives a registered command to the SRAM. It routes each read response back to the requester that issued it, with fixed latency.

---
 rtl/spsram_arbiter_if.sv | 17 +
 rtl/spsram_arbiter.sv | 106 ++++++++++
 tb/tb_spsram_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/spsram_arbiter_if.sv
// Requester-side port of the SRAM arbiter: request/grant handshake plus tagged read return.
// The requester holds req/wen/addr/wdata stable until it sees gnt at a rising edge.
interface spsram_arbiter_if #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
);
  logic               req;
  logic               wen;
  logic [BW_ADDR-1:0] addr;
  logic [BW_DATA-1:0] wdata;
  logic               gnt;
  logic               rvalid;
  logic [BW_DATA-1:0] rdata;

  modport master (output req, wen, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, wen, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/spsram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM: combinational grant, registered command,
// read data returned 2 cycles after acceptance; a losing requester stalls with its request held.
module spsram_arbiter #(
  parameter int BW_DATA   = 32,
  parameter int BW_ADDR   = 5,
  parameter int PRIO_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  spsram_arbiter_if.slave    p0,
  spsram_arbiter_if.slave    p1,
  output logic               mem_cen,
  output logic               mem_wen,
  output logic               mem_oen,
  output logic [BW_ADDR-1:0] mem_addr,
  output logic [BW_DATA-1:0] mem_wdata,
  input  logic [BW_DATA-1:0] mem_rdata
);
  localparam bit PRIO_FIXED = (PRIO_MODE != 0);

  logic               last;
  logic               gnt0;
  logic               gnt1;
  logic               xfer0;
  logic               xfer1;
  logic               xfer;
  logic               sel_wen;
  logic [BW_ADDR-1:0] sel_addr;
  logic [BW_DATA-1:0] sel_wdata;

  logic               s1_vld;
  logic               s1_port;
  logic               s2_vld;
  logic               s2_port;
  logic               rvalid0;
  logic               rvalid1;
  logic [BW_DATA-1:0] rdata0;
  logic [BW_DATA-1:0] rdata1;

  // last==1 means port 1 was served most recently, so port 0 wins the next tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (p0.req && p1.req) begin
        if (PRIO_FIXED || last) gnt0 = 1'b1;
        else                    gnt1 = 1'b1;
      end else begin
        gnt0 = p0.req;
        gnt1 = p1.req;
      end
    end
  end

  assign p0.gnt = gnt0;
  assign p1.gnt = gnt1;

  assign xfer0     = p0.req & gnt0;
  assign xfer1     = p1.req & gnt1;
  assign xfer      = xfer0 | xfer1;
  assign sel_wen   = xfer1 ? p1.wen   : p0.wen;
  assign sel_addr  = xfer1 ? p1.addr  : p0.addr;
  assign sel_wdata = xfer1 ? p1.wdata : p0.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      mem_cen   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_oen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      s1_vld    <= 1'b0;
      s1_port   <= 1'b0;
      s2_vld    <= 1'b0;
      s2_port   <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      mem_cen <= xfer;
      mem_wen <= xfer & sel_wen;
      mem_oen <= xfer & ~sel_wen;
      if (xfer) begin
        last      <= xfer1;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      // The two stages track the SRAM's command and data cycles for each read.
      s1_vld  <= xfer & ~sel_wen;
      s1_port <= xfer1;
      s2_vld  <= s1_vld;
      s2_port <= s1_port;
      rvalid0 <= s2_vld & ~s2_port;
      rvalid1 <= s2_vld & s2_port;
      if (s2_vld && !s2_port) rdata0 <= mem_rdata;
      if (s2_vld && s2_port)  rdata1 <= mem_rdata;
    end
  end

  assign p0.rvalid = rvalid0;
  assign p0.rdata  = rdata0;
  assign p1.rvalid = rvalid1;
  assign p1.rdata  = rdata1;
endmodule

// File: tb/tb_spsram_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance run the same stimulus, each with its own SRAM model.
module tb_spsram_arbiter;
  logic clk;
  logic rst;

  logic        p0_req, p0_wen, p1_req, p1_wen;
  logic [4:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;

  spsram_arbiter_if #(.BW_DATA(32), .BW_ADDR(5)) a0();
  spsram_arbiter_if #(.BW_DATA(32), .BW_ADDR(5)) a1();
  spsram_arbiter_if #(.BW_DATA(32), .BW_ADDR(5)) b0();
  spsram_arbiter_if #(.BW_DATA(32), .BW_ADDR(5)) b1();

  assign a0.req = p0_req;  assign a0.wen = p0_wen;  assign a0.addr = p0_addr;  assign a0.wdata = p0_wdata;
  assign a1.req = p1_req;  assign a1.wen = p1_wen;  assign a1.addr = p1_addr;  assign a1.wdata = p1_wdata;
  assign b0.req = p0_req;  assign b0.wen = p0_wen;  assign b0.addr = p0_addr;  assign b0.wdata = p0_wdata;
  assign b1.req = p1_req;  assign b1.wen = p1_wen;  assign b1.addr = p1_addr;  assign b1.wdata = p1_wdata;

  logic        cen_a, wen_a, oen_a, cen_b, wen_b, oen_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b, rd_a, rd_b;
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];

  spsram_arbiter #(.BW_DATA(32), .BW_ADDR(5), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .p0(a0), .p1(a1),
    .mem_cen(cen_a), .mem_wen(wen_a), .mem_oen(oen_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rd_a)
  );

  spsram_arbiter #(.BW_DATA(32), .BW_ADDR(5), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .p0(b0), .p1(b1),
    .mem_cen(cen_b), .mem_wen(wen_b), .mem_oen(oen_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rd_b)
  );

  // Registered single-port SRAM: samples the command one edge after the arbiter issues it.
  always @(posedge clk) begin
    if (cen_a) begin
      if (wen_a) mem_a[addr_a] <= wdata_a;
      else if (oen_a) rd_a <= mem_a[addr_a];
    end
    if (cen_b) begin
      if (wen_b) mem_b[addr_b] <= wdata_b;
      else if (oen_b) rd_b <= mem_b[addr_b];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-transfer code per contention edge: 0 none/write, 1 p0 read, 2 p1 read.
  int code_rr [12];
  int code_fp [12];
  int cr, cf;

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_wen = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_wen = 0; p1_addr = '0; p1_wdata = '0;
    tick(); tick(); tick();

    // Reset state; requests are ignored while reset is high.
    p0_req = 1'b1;
    #1;
    chk("rst_gnt0", a0.gnt, 0);
    chk("rst_gnt1", a1.gnt, 0);
    chk("rst_cen", cen_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_rvalid0", a0.rvalid, 0);
    chk("rst_rdata0", a0.rdata, 0);
    chk("rst_rdata1", a1.rdata, 0);
    p0_req = 1'b0;
    rst = 1'b0;
    tick();

    // Single write: one command cycle, no response.
    p0_req = 1; p0_wen = 1; p0_addr = 5'd3; p0_wdata = 32'hA5A5_0003;
    #1;
    chk("w3_gnt0", a0.gnt, 1);
    chk("w3_gnt1", a1.gnt, 0);
    tick();
    p0_req = 0;
    chk("w3_cen", cen_a, 1);
    chk("w3_wen", wen_a, 1);
    chk("w3_oen", oen_a, 0);
    chk("w3_addr", addr_a, 3);
    chk("w3_wdata", wdata_a, 32'hA5A5_0003);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("w3_idle_cen", cen_a, 0);
      chk("w3_no_rvalid", a0.rvalid, 0);
    end

    // Fill 0..31, then stream reads back-to-back.
    for (int i = 0; i < 32; i++) begin
      p0_req = 1; p0_wen = 1; p0_addr = 5'(i); p0_wdata = 32'(i);
      tick();
    end
    for (int c = 0; c < 36; c++) begin
      if (c < 32) begin
        p0_req = 1; p0_wen = 0; p0_addr = 5'(c);
      end else begin
        p0_req = 0;
      end
      tick();
      chk("stream_rvalid0", a0.rvalid, (c >= 2 && c < 34) ? 1 : 0);
      chk("stream_rvalid1", a1.rvalid, 0);
      if (c >= 2 && c < 34) chk("stream_rdata0", a0.rdata, 32'(c - 2));
    end

    // Preload through port 1 so the round-robin pointer ends on port 1.
    p0_req = 0;
    p1_req = 1; p1_wen = 1; p1_addr = 5'd5; p1_wdata = 32'h55;
    tick();
    p1_addr = 5'd9; p1_wdata = 32'h99;
    tick();
    p1_req = 0;
    tick(); tick(); tick();

    for (int k = 0; k < 12; k++) begin
      code_rr[k] = (k < 8) ? ((k % 2 == 0) ? 1 : 2) : (k == 8 ? 2 : 0);
      code_fp[k] = (k < 8) ? 1 : (k == 8 ? 2 : 0);
    end
    p0_wen = 0; p0_addr = 5'd5;
    p1_wen = 0; p1_addr = 5'd9;
    for (int k = 0; k < 12; k++) begin
      p0_req = (k < 8);
      p1_req = (k < 9);
      #1;
      chk("cont_rr_gnt0", a0.gnt, code_rr[k] == 1 ? 1 : 0);
      chk("cont_rr_gnt1", a1.gnt, code_rr[k] == 2 ? 1 : 0);
      chk("cont_fp_gnt0", b0.gnt, code_fp[k] == 1 ? 1 : 0);
      chk("cont_fp_gnt1", b1.gnt, code_fp[k] == 2 ? 1 : 0);
      tick();
      if (k >= 2) begin
        cr = code_rr[k-2];
        cf = code_fp[k-2];
        chk("cont_rr_rvalid0", a0.rvalid, cr == 1 ? 1 : 0);
        chk("cont_rr_rvalid1", a1.rvalid, cr == 2 ? 1 : 0);
        chk("cont_fp_rvalid0", b0.rvalid, cf == 1 ? 1 : 0);
        chk("cont_fp_rvalid1", b1.rvalid, cf == 2 ? 1 : 0);
        if (cr == 1) chk("cont_rr_rdata0", a0.rdata, 32'h55);
        if (cr == 2) chk("cont_rr_rdata1", a1.rdata, 32'h99);
        if (cf == 1) chk("cont_fp_rdata0", b0.rdata, 32'h55);
        if (cf == 2) chk("cont_fp_rdata1", b1.rdata, 32'h99);
      end
    end

    // Write on p1 then read-after-write on p0 the next cycle.
    p1_req = 1; p1_wen = 1; p1_addr = 5'd7; p1_wdata = 32'h1234;
    tick();
    p1_req = 0;
    p0_req = 1; p0_wen = 0; p0_addr = 5'd7;
    tick();
    p0_req = 0;
    tick();
    chk("raw_rvalid_early", a0.rvalid, 0);
    tick();
    chk("raw_rvalid", a0.rvalid, 1);
    chk("raw_rdata", a0.rdata, 32'h1234);
    chk("raw_fp_rdata", b0.rdata, 32'h1234);
    tick();
    chk("raw_rvalid_pulse", a0.rvalid, 0);
    chk("raw_rdata_hold", a0.rdata, 32'h1234);

    // Reset while a p0 read is in flight; the pointer must return to favour p0.
    p0_req = 1; p0_wen = 0; p0_addr = 5'd5;
    tick();
    p0_req = 0;
    rst = 1'b1;
    tick();
    chk("mid_cen", cen_a, 0);
    chk("mid_wen", wen_a, 0);
    chk("mid_oen", oen_a, 0);
    chk("mid_addr", addr_a, 0);
    chk("mid_wdata", wdata_a, 0);
    chk("mid_rvalid0", a0.rvalid, 0);
    chk("mid_rdata0", a0.rdata, 0);
    chk("mid_rdata1", a1.rdata, 0);
    p0_req = 1;
    #1;
    chk("mid_gnt0_in_rst", a0.gnt, 0);
    p0_req = 0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_no_rvalid0", a0.rvalid, 0);
    end
    p0_req = 1; p1_req = 1; p1_wen = 0;
    #1;
    chk("post_rst_gnt0", a0.gnt, 1);
    chk("post_rst_gnt1", a1.gnt, 0);
    tick();
    p0_req = 0; p1_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
